// File: rtl/osu_gfx_pkg.sv
// Shared screen geometry, colour index type and address helper for the
// palette-lookup front end.
package osu_gfx_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef logic [3:0] pix_idx_t;

  localparam pix_idx_t TRANSP_IDX_DEF = 4'h0;

  // by*40 + bx/8 using two shifts and adds; 40 words of 8 px per background row
  function automatic logic [13:0] bg_word_addr(input logic [8:0] by, input logic [8:0] bx);
    logic [13:0] by_w;
    by_w = {5'b0, by};
    return (by_w << 5) + (by_w << 3) + {8'b0, bx[8:3]};
  endfunction

endpackage

// File: rtl/pipe_delay.sv
// Fixed-length shift register with a parameterised reset value, used to carry
// syncs and sideband bits alongside memory reads.
module pipe_delay #(
  parameter int W = 1,
  parameter int N = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] stage [N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) stage[i] <= RST_VAL;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < N; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[N-1];

endmodule

// File: rtl/pixel_index_fetch.sv
// Turns the scan position into a 4-bit palette index, compositing a 64x64 sprite
// over a 2x-upscaled 4bpp background, with syncs delayed to stay pixel-aligned.
module pixel_index_fetch
  import osu_gfx_pkg::*;
#(
  parameter int       BG_W       = 320,
  parameter int       RD_LAT     = 2,
  parameter int       SPR_SIZE   = 64,
  parameter pix_idx_t TRANSP_IDX = TRANSP_IDX_DEF
) (
  input  logic        Clk,
  input  logic        reset_n,
  input  logic [9:0]  drawX,
  input  logic [9:0]  drawY,
  input  logic        vde_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [9:0]  spr_x,
  input  logic [9:0]  spr_y,
  input  logic        spr_en,
  output logic [13:0] bg_addr,
  input  logic [31:0] bg_rdata,
  output logic [11:0] spr_addr,
  input  logic [3:0]  spr_rdata,
  output logic [3:0]  index,
  output logic        bgd_en,
  output logic        vde_out,
  output logic        hsync_out,
  output logic        vsync_out
);

  localparam int L  = RD_LAT + 2;
  localparam int SB = $clog2(SPR_SIZE);

  logic       vs_prev;
  logic [9:0] spr_x_s, spr_y_s;
  logic       spr_en_s;

  // Sprite position is latched only at frame start so a moving sprite never tears
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      vs_prev  <= 1'b1;
      spr_x_s  <= '0;
      spr_y_s  <= '0;
      spr_en_s <= 1'b0;
    end else begin
      vs_prev <= vsync_in;
      if (vs_prev && !vsync_in) begin
        spr_x_s  <= spr_x;
        spr_y_s  <= spr_y;
        spr_en_s <= spr_en;
      end
    end
  end

  logic          blank, in_x, in_y, hit;
  logic [SB-1:0] dx, dy;

  // 11-bit compares so a box near the right/bottom edge cannot wrap around
  always_comb begin
    blank = !vde_in || (drawX >= 10'(2 * BG_W));
    in_x  = ({1'b0, drawX} >= {1'b0, spr_x_s}) &&
            ({1'b0, drawX} <  ({1'b0, spr_x_s} + 11'(SPR_SIZE)));
    in_y  = ({1'b0, drawY} >= {1'b0, spr_y_s}) &&
            ({1'b0, drawY} <  ({1'b0, spr_y_s} + 11'(SPR_SIZE)));
    hit   = spr_en_s && in_x && in_y && !blank;
    dx    = drawX[SB-1:0] - spr_x_s[SB-1:0];
    dy    = drawY[SB-1:0] - spr_y_s[SB-1:0];
  end

  logic [2:0] nib_sel_a, nib_sel_b;
  logic       hit_a, hit_b, blank_a, blank_b;

  // Blank resets high so the outputs stay dark until real pixels reach stage C
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      bg_addr   <= '0;
      spr_addr  <= '0;
      nib_sel_a <= '0;
      hit_a     <= 1'b0;
      blank_a   <= 1'b1;
    end else begin
      bg_addr   <= blank ? 14'd0 : bg_word_addr(drawY[9:1], drawX[9:1]);
      spr_addr  <= hit ? 12'({dy, dx}) : 12'd0;
      nib_sel_a <= drawX[3:1];
      hit_a     <= hit;
      blank_a   <= blank;
    end
  end

  pipe_delay #(.W(5), .N(RD_LAT), .RST_VAL(5'b00001)) u_side (
    .clk   (Clk),
    .rst_n (reset_n),
    .din   ({nib_sel_a, hit_a, blank_a}),
    .dout  ({nib_sel_b, hit_b, blank_b})
  );

  pipe_delay #(.W(3), .N(L), .RST_VAL(3'b011)) u_sync (
    .clk   (Clk),
    .rst_n (reset_n),
    .din   ({vde_in, hsync_in, vsync_in}),
    .dout  ({vde_out, hsync_out, vsync_out})
  );

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      index  <= '0;
      bgd_en <= 1'b0;
    end else if (blank_b) begin
      index  <= '0;
      bgd_en <= 1'b0;
    end else if (hit_b && (spr_rdata != TRANSP_IDX)) begin
      index  <= spr_rdata;
      bgd_en <= 1'b0;
    end else begin
      index  <= bg_rdata[4*nib_sel_b +: 4];
      bgd_en <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pixel_index_fetch.sv
// Directed bench: two instances (RD_LAT=2 and RD_LAT=1) share stimulus, each
// with its own BRAM/ROM latency model.
module tb_pixel_index_fetch;

  logic       Clk = 1'b0;
  logic       reset_n;
  logic [9:0] drawX, drawY, spr_x, spr_y;
  logic       vde_in, hsync_in, vsync_in, spr_en;

  logic [13:0] bgAddrA, bgAddrB;
  logic [11:0] sprAddrA, sprAddrB;
  logic [31:0] bgRdataA, bgRdataB;
  logic [3:0]  sprRdataA, sprRdataB;
  logic [3:0]  indexA, indexB;
  logic        bgdEnA, bgdEnB, vdeOutA, vdeOutB;
  logic        hsyncOutA, hsyncOutB, vsyncOutA, vsyncOutB;

  int vectorCount = 0;
  int missCount   = 0;

  always #5 Clk = ~Clk;

  pixel_index_fetch #(.RD_LAT(2)) dutA (
    .Clk(Clk), .reset_n(reset_n), .drawX(drawX), .drawY(drawY),
    .vde_in(vde_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .spr_x(spr_x), .spr_y(spr_y), .spr_en(spr_en),
    .bg_addr(bgAddrA), .bg_rdata(bgRdataA), .spr_addr(sprAddrA), .spr_rdata(sprRdataA),
    .index(indexA), .bgd_en(bgdEnA), .vde_out(vdeOutA), .hsync_out(hsyncOutA), .vsync_out(vsyncOutA)
  );

  pixel_index_fetch #(.RD_LAT(1)) dutB (
    .Clk(Clk), .reset_n(reset_n), .drawX(drawX), .drawY(drawY),
    .vde_in(vde_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .spr_x(spr_x), .spr_y(spr_y), .spr_en(spr_en),
    .bg_addr(bgAddrB), .bg_rdata(bgRdataB), .spr_addr(sprAddrB), .spr_rdata(sprRdataB),
    .index(indexB), .bgd_en(bgdEnB), .vde_out(vdeOutB), .hsync_out(hsyncOutB), .vsync_out(vsyncOutB)
  );

  // Memory models: BRAM word k holds {8{k[3:0]}}, sprite ROM returns dx[3:0]
  logic [31:0] bgA1 = '0, bgA2 = '0, bgB1 = '0;
  logic [3:0]  spA1 = '0, spA2 = '0, spB1 = '0;

  always @(posedge Clk) begin
    bgA1 <= {8{bgAddrA[3:0]}};
    bgA2 <= bgA1;
    spA1 <= sprAddrA[3:0];
    spA2 <= spA1;
    bgB1 <= {8{bgAddrB[3:0]}};
    spB1 <= sprAddrB[3:0];
  end

  assign bgRdataA  = bgA2;
  assign sprRdataA = spA2;
  assign bgRdataB  = bgB1;
  assign sprRdataB = spB1;

  task automatic tickClock();
    @(posedge Clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [9:0] x, input logic [9:0] y, input logic vde);
    drawX  = x;
    drawY  = y;
    vde_in = vde;
  endtask

  task automatic vsyncPulse();
    vsync_in = 1'b0;
    tickClock();
    vsync_in = 1'b1;
    tickClock();
  endtask

  // Hold one pixel long enough for both instances; addresses after 1 cycle,
  // RD_LAT=1 output after 3, RD_LAT=2 output after 4
  task automatic runPixel(input string tag, input logic [9:0] x, input logic [9:0] y, input logic vde,
                          input logic [13:0] expBg, input logic [11:0] expSpr,
                          input logic [3:0] expIdx, input logic expBgd);
    applyStimulus(x, y, vde);
    tickClock();
    checkOutput({tag, "_bgaddr"}, 32'(bgAddrA), 32'(expBg));
    checkOutput({tag, "_spraddr"}, 32'(sprAddrA), 32'(expSpr));
    tickClock();
    tickClock();
    checkOutput({tag, "_idxB"}, 32'(indexB), 32'(expIdx));
    checkOutput({tag, "_bgdB"}, 32'(bgdEnB), 32'(expBgd));
    tickClock();
    checkOutput({tag, "_idxA"}, 32'(indexA), 32'(expIdx));
    checkOutput({tag, "_bgdA"}, 32'(bgdEnA), 32'(expBgd));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected summary");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n  = 1'b0;
    applyStimulus(10'd0, 10'd0, 1'b0);
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    spr_x    = '0;
    spr_y    = '0;
    spr_en   = 1'b0;
    tickClock();
    tickClock();

    checkOutput("rst_idx",     32'(indexA), 32'd0);
    checkOutput("rst_bgd",     32'(bgdEnA), 32'd0);
    checkOutput("rst_vde",     32'(vdeOutA), 32'd0);
    checkOutput("rst_hsync",   32'(hsyncOutA), 32'd1);
    checkOutput("rst_vsync",   32'(vsyncOutA), 32'd1);
    checkOutput("rst_bgaddr",  32'(bgAddrA), 32'd0);
    checkOutput("rst_spraddr", 32'(sprAddrA), 32'd0);

    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) tickClock();

    // Single background pixel with exact latency on both instances
    applyStimulus(10'd10, 10'd6, 1'b1);
    tickClock();
    checkOutput("t1_bgaddr", 32'(bgAddrA), 32'd120);
    tickClock();
    checkOutput("t1_idxB_early", 32'(indexB), 32'd0);
    tickClock();
    checkOutput("t1_idxB", 32'(indexB), 32'd8);
    checkOutput("t1_idxA_early", 32'(indexA), 32'd0);
    tickClock();
    checkOutput("t1_idxA", 32'(indexA), 32'd8);
    checkOutput("t1_bgdA", 32'(bgdEnA), 32'd1);
    checkOutput("t1_vdeA", 32'(vdeOutA), 32'd1);

    // Streaming sweep across a word boundary with a toggling hsync
    applyStimulus(10'd0, 10'd2, 1'b1);
    for (int i = 0; i < 35; i++) begin
      int j;
      if (i < 32) begin
        drawX    = 10'(i);
        hsync_in = ((i % 3) != 0);
      end
      tickClock();
      if (i < 32) checkOutput("sweep_bgaddr", 32'(bgAddrA), (i < 16) ? 32'd40 : 32'd41);
      if (i >= 3) begin
        j = i - 3;
        checkOutput("sweep_idx", 32'(indexA), (j < 16) ? 32'd8 : 32'd9);
        checkOutput("sweep_bgd", 32'(bgdEnA), 32'd1);
        checkOutput("sweep_hsync", 32'(hsyncOutA), ((j % 3) != 0) ? 32'd1 : 32'd0);
      end
    end
    hsync_in = 1'b1;

    // Sprite at (100,50), latched on a vsync falling edge
    spr_x  = 10'd100;
    spr_y  = 10'd50;
    spr_en = 1'b1;
    vsyncPulse();
    runPixel("spr_hit",    10'd103, 10'd50,  1'b1, 14'd1006, 12'h003, 4'd3,  1'b0);
    runPixel("spr_transp", 10'd100, 10'd50,  1'b1, 14'd1006, 12'h000, 4'd14, 1'b1);
    runPixel("spr_out_l",  10'd99,  10'd50,  1'b1, 14'd1006, 12'h000, 4'd14, 1'b1);
    runPixel("spr_right",  10'd163, 10'd50,  1'b1, 14'd1010, 12'd63,  4'd15, 1'b0);
    runPixel("spr_out_r",  10'd164, 10'd50,  1'b1, 14'd1010, 12'h000, 4'd2,  1'b1);
    runPixel("spr_bottom", 10'd101, 10'd113, 1'b1, 14'd2246, 12'hFC1, 4'd1,  1'b0);
    runPixel("spr_out_b",  10'd101, 10'd114, 1'b1, 14'd2286, 12'h000, 4'd14, 1'b1);

    // Mid-frame move is ignored until the next vsync edge
    spr_x = 10'd600;
    runPixel("shadow_hold", 10'd103, 10'd50, 1'b1, 14'd1006, 12'h003, 4'd3,  1'b0);
    vsyncPulse();
    runPixel("shadow_new",  10'd103, 10'd50, 1'b1, 14'd1006, 12'h000, 4'd14, 1'b1);
    runPixel("edge_639",    10'd639, 10'd50, 1'b1, 14'd1039, 12'd39,  4'd7,  1'b0);
    runPixel("edge_599",    10'd599, 10'd50, 1'b1, 14'd1037, 12'h000, 4'd13, 1'b1);
    runPixel("edge_601",    10'd601, 10'd50, 1'b1, 14'd1037, 12'd1,   4'd1,  1'b0);
    runPixel("edge_640",    10'd640, 10'd50, 1'b1, 14'd0,    12'h000, 4'd0,  1'b0);

    // Blanking and sync alignment
    runPixel("vde_off", 10'd10, 10'd6, 1'b0, 14'd0, 12'h000, 4'd0, 1'b0);
    checkOutput("vde_out_low", 32'(vdeOutA), 32'd0);
    runPixel("x700", 10'd700, 10'd6, 1'b1, 14'd0, 12'h000, 4'd0, 1'b0);
    vsync_in = 1'b0;
    tickClock();
    vsync_in = 1'b1;
    tickClock();
    tickClock();
    checkOutput("vsync_dly_B", 32'(vsyncOutB), 32'd0);
    checkOutput("vsync_dly_A_early", 32'(vsyncOutA), 32'd1);
    tickClock();
    checkOutput("vsync_dly_A", 32'(vsyncOutA), 32'd0);
    tickClock();
    checkOutput("vsync_dly_A_end", 32'(vsyncOutA), 32'd1);

    // Asynchronous reset in the middle of a sprite hit
    runPixel("pre_reset", 10'd601, 10'd50, 1'b1, 14'd1037, 12'd1, 4'd1, 1'b0);
    reset_n = 1'b0;
    #1;
    checkOutput("areset_idx",   32'(indexA), 32'd0);
    checkOutput("areset_bgd",   32'(bgdEnA), 32'd0);
    checkOutput("areset_vde",   32'(vdeOutA), 32'd0);
    checkOutput("areset_addr",  32'(sprAddrA), 32'd0);
    checkOutput("areset_idxB",  32'(indexB), 32'd0);
    tickClock();
    tickClock();
    reset_n = 1'b1;
    for (int t = 1; t <= 4; t++) begin
      tickClock();
      checkOutput("rel_idxA", 32'(indexA), (t < 4) ? 32'd0 : 32'd13);
      checkOutput("rel_bgdA", 32'(bgdEnA), (t < 4) ? 32'd0 : 32'd1);
      checkOutput("rel_vdeA", 32'(vdeOutA), (t < 4) ? 32'd0 : 32'd1);
      checkOutput("rel_idxB", 32'(indexB), (t < 3) ? 32'd0 : 32'd13);
    end
    vsyncPulse();
    runPixel("post_vsync", 10'd601, 10'd50, 1'b1, 14'd1037, 12'd1, 4'd1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
